// File: rtl/uart_rx_top_if.sv
// Host-side bundle for uart_rx_top: serial line and frame configuration in, received byte and status out.
interface uart_rx_top_if;
   logic       data_in;
   logic [1:0] baud_rate;
   logic [1:0] parity_type;
   logic       stop_bits;
   logic       data_length;
   logic [7:0] data_out;
   logic       rx_active;
   logic       rx_done;
   logic       parity_error;
   logic       stop_error;

   modport master (
      output data_in, baud_rate, parity_type, stop_bits, data_length,
      input  data_out, rx_active, rx_done, parity_error, stop_error
   );

   modport slave (
      input  data_in, baud_rate, parity_type, stop_bits, data_length,
      output data_out, rx_active, rx_done, parity_error, stop_error
   );
endinterface

// File: rtl/uart_rx_top.sv
// uart_rx_top: serial receiver for the uart_tx_top frame format.
// Start bit, 7/8 data bits LSB first, optional odd/even parity, 1/2 stop bits.
// Optional feature macro UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit sample.
module uart_rx_top #(
   parameter int unsigned DIV_B0 = 1302,
   parameter int unsigned DIV_B1 = 651,
   parameter int unsigned DIV_B2 = 326,
   parameter int unsigned DIV_B3 = 163
) (
   input  logic         clock,
   input  logic         rst,
   uart_rx_top_if.slave bus
);
   localparam int unsigned CNT_W = 11;

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t           state_q;
   logic             sync1_q, sync2_q, prev_q;
   logic [1:0]       baud_q, ptype_q;
   logic             stop2_q, len8_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       sh_q;
   logic             par_q, perr_q, serr_q, stop_idx_q;
   logic [7:0]       data_out_q;
   logic             rx_active_q, rx_done_q, parity_error_q, stop_error_q;

   logic [CNT_W-1:0] div_c, target_c;
   logic             tick_c, sample_c, fall_c, has_par_c, last_data_c, serr_c;

   // Two-flop synchronizer plus one delayed copy for edge detection and voting
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         sync1_q <= bus.data_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Bit period for the latched baud, sample timing and bit value
   always_comb begin
      div_c = CNT_W'(DIV_B0);
      case (baud_q)
         2'b00:   div_c = CNT_W'(DIV_B0);
         2'b01:   div_c = CNT_W'(DIV_B1);
         2'b10:   div_c = CNT_W'(DIV_B2);
         default: div_c = CNT_W'(DIV_B3);
      endcase
      target_c    = (state_q == S_START) ? (div_c >> 1) : div_c;
      tick_c      = (cnt_q == target_c - CNT_W'(1));
`ifdef UART_RX_MAJORITY_EN
      // sync1_q already holds the value sync2_q takes one clock later (mid+1)
      sample_c    = (prev_q & sync2_q) | (prev_q & sync1_q) | (sync2_q & sync1_q);
`else
      sample_c    = sync2_q;
`endif
      fall_c      = prev_q & ~sync2_q;
      has_par_c   = (ptype_q == 2'b01) || (ptype_q == 2'b10);
      last_data_c = len8_q ? (idx_q == 3'd7) : (idx_q == 3'd6);
      serr_c      = serr_q | ~sample_c;
   end

   // Frame FSM with registered host-side outputs
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         baud_q         <= 2'b00;
         ptype_q        <= 2'b00;
         stop2_q        <= 1'b0;
         len8_q         <= 1'b0;
         cnt_q          <= '0;
         idx_q          <= '0;
         sh_q           <= '0;
         par_q          <= 1'b0;
         perr_q         <= 1'b0;
         serr_q         <= 1'b0;
         stop_idx_q     <= 1'b0;
         data_out_q     <= '0;
         rx_active_q    <= 1'b0;
         rx_done_q      <= 1'b0;
         parity_error_q <= 1'b0;
         stop_error_q   <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         if (state_q != S_IDLE) cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
         case (state_q)
            S_IDLE: begin
               if (fall_c) begin
                  baud_q      <= bus.baud_rate;
                  ptype_q     <= bus.parity_type;
                  stop2_q     <= bus.stop_bits;
                  len8_q      <= bus.data_length;
                  cnt_q       <= '0;
                  idx_q       <= '0;
                  sh_q        <= '0;
                  par_q       <= 1'b0;
                  perr_q      <= 1'b0;
                  serr_q      <= 1'b0;
                  stop_idx_q  <= 1'b0;
                  rx_active_q <= 1'b1;
                  state_q     <= S_START;
               end
            end
            S_START: begin
               if (tick_c) begin
                  if (sample_c) begin
                     rx_active_q <= 1'b0;
                     state_q     <= S_IDLE;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (tick_c) begin
                  sh_q[idx_q] <= sample_c;
                  par_q       <= par_q ^ sample_c;
                  idx_q       <= idx_q + 3'd1;
                  if (last_data_c) state_q <= has_par_c ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (tick_c) begin
                  // odd: total ones must be odd; even: total ones must be even
                  perr_q  <= (ptype_q == 2'b01) ? ~(par_q ^ sample_c) : (par_q ^ sample_c);
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (tick_c) begin
                  if (stop2_q && !stop_idx_q) begin
                     stop_idx_q <= 1'b1;
                     serr_q     <= serr_c;
                  end else begin
                     data_out_q     <= sh_q;
                     parity_error_q <= perr_q;
                     stop_error_q   <= serr_c;
                     rx_done_q      <= 1'b1;
                     rx_active_q    <= 1'b0;
                     state_q        <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.data_out     = data_out_q;
   assign bus.rx_active    = rx_active_q;
   assign bus.rx_done      = rx_done_q;
   assign bus.parity_error = parity_error_q;
   assign bus.stop_error   = stop_error_q;
endmodule
